inv_sub_bytes_seq: RTL and testbench



---
 rtl/inv_sub_bytes_seq.sv | 145 ++++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes engine: substitutes LANES bytes of a 128-bit state per
// clock and holds the finished state behind a valid/ready output handshake.
module inv_sub_bytes_seq #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  localparam int unsigned N  = 16 / LANES;
  localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [127:0]            work;
  logic [127:0]            work_nxt;
  logic [GW-1:0]           grp;
  logic                    last_grp;
  logic [LANES-1:0][7:0]   lane_in;
  logic [LANES-1:0][7:0]   lane_out;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 naturally
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int unsigned i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int unsigned i = 0; i < 8; i++) begin
      r[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
    end
    return r ^ 8'h05;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_inv(inv_affine(b));
  endfunction

  assign last_grp = (grp == GW'(N - 1));

  // Lane mux: pick the LANES bytes of the current group and substitute them
  always_comb begin
    lane_in = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned g = 0; g < N; g++) begin
        if (grp == GW'(g)) lane_in[l] = work[127 - 8 * (g * LANES + l) -: 8];
      end
    end
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_out[l] = inv_sbox(lane_in[l]);
    end
  end

  always_comb begin
    work_nxt = work;
    unique case (state)
      IDLE: if (in_valid) work_nxt = in_state;
      BUSY: begin
        for (int unsigned g = 0; g < N; g++) begin
          for (int unsigned l = 0; l < LANES; l++) begin
            if (grp == GW'(g)) work_nxt[127 - 8 * (g * LANES + l) -: 8] = lane_out[l];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work <= '0;
      grp  <= '0;
    end else begin
      work <= work_nxt;
      if (state == IDLE)      grp <= '0;
      else if (state == BUSY) grp <= last_grp ? '0 : grp + GW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last_grp)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = !rst;
        busy     = 1'b0;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_state = work;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq at LANES = 1, 2, 4, 8, 16: per-instance driver plus
// scoreboard monitor, reference built from a brute-force GF(2^8) S-box table.
module tb_inv_sub_bytes_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  logic [7:0] sbox_tab [256];
  logic [7:0] inv_tab  [256];

  typedef struct {
    logic [127:0] expv;
    int unsigned  acc;
  } item_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  // Carry-less product reduced by long division with 0x11b
  function automatic int gmul(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) if (((b >> i) & 1) == 1) p = p ^ (a << i);
    for (int i = 14; i >= 8; i--) if (((p >> i) & 1) == 1) p = p ^ ('h11b << (i - 8));
    return p;
  endfunction

  // Forward S-box from its definition, then invert the permutation
  initial begin
    int inv;
    int s;
    for (int b = 0; b < 256; b++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (gmul(b, y) == 1) inv = y;
      s = 0;
      for (int r = 0; r < 5; r++) s = s ^ (((inv << r) | (inv >> (8 - r))) & 'hff);
      sbox_tab[b] = 8'(s ^ 'h63);
    end
    for (int b = 0; b < 256; b++) inv_tab[sbox_tab[b]] = 8'(b);
  end

  function automatic logic [127:0] model(input logic [127:0] x);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[127 - 8 * k -: 8] = inv_tab[x[127 - 8 * k -: 8]];
    return r;
  endfunction

  for (genvar gi = 0; gi < 5; gi++) begin : gl
    localparam int unsigned L = 1 << gi;
    localparam int unsigned N = 16 / L;

    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;
    logic         done;
    logic         prev_valid = 1'b0;
    item_t        q[$];

    inv_sub_bytes_seq #(.LANES(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .busy      (busy)
    );

    // Monitor: compare every presented result against the scoreboard head
    always @(negedge clk) begin
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL spurious_out L=%0d actual=%h required=no output", L, out_state);
        end else begin
          if (prev_valid !== 1'b1)
            chk($sformatf("latency L=%0d", L), 128'(cyc - q[0].acc), 128'(N));
          chk($sformatf("data L=%0d", L), out_state, q[0].expv);
          if (out_ready === 1'b1) void'(q.pop_front());
        end
      end
      prev_valid = out_valid;
    end

    task automatic send(input logic [127:0] d, input logic [127:0] e, output int unsigned a);
      int unsigned w;
      w = 0;
      a = 0;
      in_state = d;
      in_valid = 1'b1;
      @(negedge clk);
      while (in_ready !== 1'b1 && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (in_ready !== 1'b1) begin
        total++;
        $display("FAIL accept_timeout L=%0d actual=%b required=1", L, in_ready);
        in_valid = 1'b0;
      end else begin
        @(posedge clk);
        #1;
        a = cyc;
        q.push_back('{expv: e, acc: cyc});
        in_valid = 1'b0;
      end
    endtask

    task automatic wait_valid();
      int unsigned w;
      w = 0;
      while (out_valid !== 1'b1 && w < 100) begin
        @(posedge clk);
        #1;
        w++;
      end
      if (out_valid !== 1'b1) begin
        total++;
        $display("FAIL valid_timeout L=%0d actual=%b required=1", L, out_valid);
      end
    endtask

    task automatic drain();
      int unsigned w;
      w = 0;
      while ((q.size() != 0 || busy !== 1'b0) && w < 200) begin
        @(posedge clk);
        #1;
        w++;
      end
      chk($sformatf("drain L=%0d", L), 128'(q.size()), 128'(0));
    endtask

    initial begin
      logic [127:0] d;
      int unsigned  a;
      int unsigned  pa;
      string        s;
      done      = 1'b0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_state  = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("rst_in_ready L=%0d", L), 128'(in_ready), 128'(0));
      chk($sformatf("rst_out_valid L=%0d", L), 128'(out_valid), 128'(0));
      chk($sformatf("rst_busy L=%0d", L), 128'(busy), 128'(0));
      chk($sformatf("rst_out_state L=%0d", L), out_state, 128'(0));
      rst = 1'b0;
      #1;
      chk($sformatf("post_rst_in_ready L=%0d", L), 128'(in_ready), 128'(1));

      // Known vector, all-zero, all-ones
      send(128'h638293c31bfc33f5c4eeacea4bc12816, 128'h00112233445566778899aabbccddeeff, a);
      wait_valid();
      if (L == 4) begin
        s = "";
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) s = {s, $sformatf("%h ", out_state[127 - 8 * (c * 4 + r) -: 8])};
          s = {s, "| "};
        end
        $display("L=%0d out[row][col]: %s", L, s);
      end
      send(128'h0, {16{8'h52}}, a);
      send({16{8'hff}}, {16{8'h7d}}, a);
      drain();

      // Backpressure: hold DONE, ignore new input, then one-cycle release
      out_ready = 1'b0;
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, model(d), a);
      wait_valid();
      for (int i = 0; i < 10; i++) begin
        in_valid = 1'b1;
        in_state = ~d;
        @(posedge clk);
        #1;
        chk($sformatf("bp_in_ready L=%0d", L), 128'(in_ready), 128'(0));
        chk($sformatf("bp_out_valid L=%0d", L), 128'(out_valid), 128'(1));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk($sformatf("bp_release_in_ready L=%0d", L), 128'(in_ready), 128'(1));
      chk($sformatf("bp_release_out_valid L=%0d", L), 128'(out_valid), 128'(0));
      out_ready = 1'b1;
      drain();

      // Reset on the second BUSY cycle (the only one when N == 1)
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, model(d), a);
      if (N >= 2) begin
        @(posedge clk);
        #1;
      end
      rst = 1'b1;
      q.delete();
      @(posedge clk);
      #1;
      chk($sformatf("abort_out_valid L=%0d", L), 128'(out_valid), 128'(0));
      chk($sformatf("abort_busy L=%0d", L), 128'(busy), 128'(0));
      chk($sformatf("abort_out_state L=%0d", L), out_state, 128'(0));
      chk($sformatf("abort_in_ready L=%0d", L), 128'(in_ready), 128'(0));
      rst = 1'b0;
      #1;
      chk($sformatf("abort_release_in_ready L=%0d", L), 128'(in_ready), 128'(1));
      send(128'h638293c31bfc33f5c4eeacea4bc12816, 128'h00112233445566778899aabbccddeeff, a);
      drain();

      // Exhaustive round trip, back to back, checking the accept period
      pa = 0;
      for (int b = 0; b < 256; b++) begin
        send({16{sbox_tab[b]}}, {16{8'(b)}}, a);
        if (b > 0) chk($sformatf("period L=%0d b=%0d", L, b), 128'(a - pa), 128'(N + 2));
        pa = a;
      end
      drain();

      // Random states with random output stalls
      for (int i = 0; i < 30; i++) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        send(d, model(d), a);
        out_ready = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, N + 3)) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      drain();
      done = 1'b1;
    end
  end

  initial begin
    int unsigned w;
    w = 0;
    while (!(gl[0].done === 1'b1 && gl[1].done === 1'b1 && gl[2].done === 1'b1 &&
             gl[3].done === 1'b1 && gl[4].done === 1'b1) && w < 60000) begin
      @(posedge clk);
      w++;
    end
    if (w >= 60000) begin
      total++;
      $display("FAIL global_timeout actual=%0d cycles required=all instances done", w);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
